// File: rtl/profiler_dump_streamer.sv
// Snapshots all profiler counters on a dump request and streams them out as
// a framed byte sequence: SYNC_BYTE, payload (counter 0 first, MSB first), XOR checksum.
module profiler_dump_streamer #(
    parameter int          NUM_COUNTERS  = 11,
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]   counters_in,
    input  logic                                    dump_req,
    output logic [7:0]                              tx_data,
    output logic                                    tx_valid,
    input  logic                                    tx_ready,
    output logic                                    busy,
    output logic                                    done
);
    localparam int BPC    = COUNTER_WIDTH / 8;
    localparam int NBYTES = NUM_COUNTERS * BPC;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;

    state_t                                 state, state_nxt;
    logic [NUM_COUNTERS*COUNTER_WIDTH-1:0]  snap;
    logic [NBYTES-1:0][7:0]                 pay;
    logic [IDX_W-1:0]                       idx, idx_nxt, idx_inc;
    logic [7:0]                             csum, csum_nxt, data_nxt;
    logic                                   xfer, capture;
    logic                                   valid_nxt, busy_nxt, done_nxt;

    // Byte view of the snapshot in transmit order.
    for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_cnt
        for (genvar b = 0; b < BPC; b++) begin : g_byte
            assign pay[k*BPC + b] = snap[k*COUNTER_WIDTH + COUNTER_WIDTH - 1 - 8*b -: 8];
        end
    end

    assign xfer    = tx_valid & tx_ready;
    assign idx_inc = idx + 1'b1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        csum_nxt  = csum;
        data_nxt  = tx_data;
        valid_nxt = tx_valid;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    capture   = 1'b1;
                    csum_nxt  = 8'h00;
                    data_nxt  = SYNC_BYTE;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    idx_nxt   = '0;
                    data_nxt  = pay[0];
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    csum_nxt = csum ^ tx_data;
                    if (idx == LAST_IDX) begin
                        // Present the final checksum directly, including the byte just accepted.
                        data_nxt  = csum ^ tx_data;
                        state_nxt = CHECKSUM;
                    end else begin
                        idx_nxt  = idx_inc;
                        data_nxt = pay[idx_inc];
                    end
                end
            end
            CHECKSUM: begin
                if (xfer) begin
                    data_nxt  = 8'h00;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            snap     <= '0;
            idx      <= '0;
            csum     <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            csum     <= csum_nxt;
            tx_data  <= data_nxt;
            tx_valid <= valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            if (capture) snap <= counters_in;
        end
    end
endmodule

// File: tb/tb_profiler_dump_streamer.sv
// Bench for profiler_dump_streamer: table-driven frames plus random frames,
// all checked against a byte-queue model of the frame built from the captured counters.
module tb_profiler_dump_streamer;
    localparam int NC   = 11;
    localparam int CW   = 32;
    localparam int FLEN = 2 + NC*CW/8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*CW-1:0]  counters_in;
    logic              dump_req;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [31:0] cur [NC];

    profiler_dump_streamer #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .counters_in(counters_in), .dump_req(dump_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          pct;
        logic [7:0]  exp_cs;
        bit          hold;
        bit          mid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_cnt();
        for (int k = 0; k < NC; k++) counters_in[k*CW +: CW] = cur[k];
    endtask

    // Drives one frame from cur[], collects accepted bytes and compares to the model.
    task automatic run_frame(input int pct, input bit hold, input bit mid,
                             input bit use_cs, input logic [7:0] exp_cs);
        logic [7:0] exp_q[$];
        logic [7:0] got[$];
        logic [7:0] cs;
        logic [7:0] stall_d;
        logic [31:0] scr;
        bit stalled, prev_hs, fin;
        int cyc, vcyc;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NC; k++)
            for (int b = 0; b < CW/8; b++) begin
                exp_q.push_back(8'(cur[k] >> (CW - 8 - 8*b)));
                cs ^= 8'(cur[k] >> (CW - 8 - 8*b));
            end
        exp_q.push_back(cs);

        load_cnt();
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = hold;
        scr = 32'h0; stalled = 0; prev_hs = 0; fin = 0; cyc = 0; vcyc = 0; stall_d = 8'h00;
        while (!fin && cyc < 2000) begin
            tx_ready = ($urandom_range(0, 99) < pct);
            counters_in[CW-1:0] = scr;   // counter 0 wraps to 0 and counts on after capture
            scr++;
            for (int k = 1; k < NC; k++) counters_in[k*CW +: CW] = $urandom;
            if (mid && !hold) dump_req = (cyc == 10);
            @(negedge clk);
            if (stalled) chk("stall_hold", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, stall_d});
            if (done) begin
                chk("done_after_cs", {31'h0, prev_hs && (got.size() == FLEN)}, 32'h1);
                chk("done_busy_valid_low", {30'h0, busy, tx_valid}, 32'h0);
                fin = 1;
            end else begin
                chk("in_frame_valid_busy", {30'h0, tx_valid, busy}, 32'h3);
            end
            prev_hs = tx_valid & tx_ready;
            if (prev_hs) got.push_back(tx_data);
            stalled = tx_valid & ~tx_ready;
            stall_d = tx_data;
            if (tx_valid) vcyc++;
            cyc++;
            @(posedge clk); #1;
        end
        if (!fin) chk("frame_timeout", 32'h0, 32'h1);
        chk("frame_len", got.size(), FLEN);
        for (int i = 0; i < FLEN && i < got.size(); i++)
            if (got[i] !== exp_q[i]) chk($sformatf("byte[%0d]", i), got[i], exp_q[i]);
            else checks++;
        if (use_cs && got.size() == FLEN) chk("table_csum", got[FLEN-1], exp_cs);
        if (pct >= 100) chk("no_gap_valid_cycles", vcyc, FLEN);

        if (hold) begin
            tx_ready = 1'b1;
            @(negedge clk);
            chk("retrigger_header", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA5});
            @(posedge clk); #1;
            dump_req = 1'b0;
            cyc = 0;
            while (cyc < 200) begin
                @(negedge clk);
                if (done) break;
                cyc++;
                @(posedge clk); #1;
            end
            chk("retrigger_drain", {31'h0, done}, 32'h1);
            @(posedge clk); #1;
        end else begin
            dump_req = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("idle_no_requeue", {30'h0, tx_valid, busy}, 32'h0);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        vec_t vecs [5];
        int acc, guard;
        vecs[0] = '{32'h01020300, 32'd1, 100, 8'h0B, 1'b0, 1'b0};
        vecs[1] = '{32'h01020300, 32'd1, 45,  8'h0B, 1'b0, 1'b1};
        vecs[2] = '{32'h00000000, 32'd0, 100, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{32'h11223344, 32'd0, 70,  8'h44, 1'b1, 1'b0};
        vecs[4] = '{32'hFFFFFFFF, 32'd0, 30,  8'h00, 1'b0, 1'b1};

        rst = 1'b0; dump_req = 1'b1; tx_ready = 1'b0; counters_in = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {21'h0, tx_valid, busy, done, tx_data}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b1; dump_req = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < NC; k++) cur[k] = vecs[v].base + vecs[v].step * k;
            run_frame(vecs[v].pct, vecs[v].hold, vecs[v].mid, 1'b1, vecs[v].exp_cs);
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NC; k++) cur[k] = $urandom;
            run_frame($urandom_range(20, 100), 1'b0, r[0], 1'b0, 8'h00);
        end

        // Reset in the middle of a frame, then a clean frame must follow.
        for (int k = 0; k < NC; k++) cur[k] = $urandom;
        load_cnt();
        tx_ready = 1'b1; dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        acc = 0; guard = 0;
        while (acc < 21 && guard < 100) begin
            @(negedge clk);
            if (tx_valid && tx_ready) acc++;
            guard++;
            @(posedge clk); #1;
        end
        chk("pre_reset_bytes", acc, 21);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", {21'h0, tx_valid, busy, done, tx_data}, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < NC; k++) cur[k] = $urandom;
        run_frame(60, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
